// File: rtl/switch_debouncer.sv
// Per-channel two-flop synchronizer plus counter-based debouncer with edge strobes.
// Exposes the clean levels, threshold and bounce-seen flags over an Avalon-MM slave.
module switch_debouncer #(
  parameter int WIDTH           = 4,
  parameter int CNT_W           = 16,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  logic [CNT_W-1:0] thr_reg;
  logic [CNT_W-1:0] thr_lim;
  logic [WIDTH-1:0] s1_reg;
  logic [WIDTH-1:0] s2_reg;
  logic [WIDTH-1:0] clean_reg;
  logic [WIDTH-1:0] rise_reg;
  logic [WIDTH-1:0] fall_reg;
  logic [WIDTH-1:0] bnc_reg;
  logic [WIDTH-1:0] bnc_set;
  logic [WIDTH-1:0] flip;
  logic [31:0]      rd_next;
  logic             wr_thr;
  logic             wr_bnc;
  logic             unused_wdata;

  assign wr_thr = chipselect && !write_n && (address == 2'd1);
  assign wr_bnc = chipselect && !write_n && (address == 2'd2);

  // A zero threshold behaves as one, so the limit never underflows.
  assign thr_lim = (thr_reg == '0) ? '0 : thr_reg - CNT_W'(1);

  assign unused_wdata = &{1'b0, writedata};

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_reg <= '0;
      end else if (s2_reg[gi] == clean_reg[gi]) begin
        cnt_reg <= '0;
      end else if (cnt_reg >= thr_lim) begin
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end

    assign flip[gi]    = (s2_reg[gi] != clean_reg[gi]) && (cnt_reg >= thr_lim);
    // Level fell back to the clean value before the count completed.
    assign bnc_set[gi] = (s2_reg[gi] == clean_reg[gi]) && (cnt_reg != '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_reg    <= '0;
      s2_reg    <= '0;
      clean_reg <= '0;
      rise_reg  <= '0;
      fall_reg  <= '0;
      bnc_reg   <= '0;
    end else begin
      s1_reg    <= sw_raw;
      s2_reg    <= s1_reg;
      clean_reg <= clean_reg ^ flip;
      rise_reg  <= flip & s2_reg;
      fall_reg  <= flip & ~s2_reg;
      // A new bounce outranks a clear landing in the same cycle.
      bnc_reg   <= (wr_bnc ? '0 : bnc_reg) | bnc_set;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      thr_reg <= CNT_W'(DEBOUNCE_CYCLES);
    end else if (wr_thr) begin
      thr_reg <= writedata[CNT_W-1:0];
    end
  end

  always_comb begin
    rd_next = '0;
    case (address)
      2'd0:    rd_next = 32'(clean_reg);
      2'd1:    rd_next = 32'(thr_reg);
      2'd2:    rd_next = 32'(bnc_reg);
      default: rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_next;
    end
  end

  assign sw_clean   = clean_reg;
  assign rise_pulse = rise_reg;
  assign fall_pulse = fall_reg;

endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer: timestamp-based reference model compared
// every cycle, plus directed scenarios with hand-computed latencies.
module tb_switch_debouncer;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] sw_raw = '0;
  logic [1:0]   address = '0;
  logic         chipselect = 1'b0;
  logic         write_n = 1'b1;
  logic [31:0]  writedata = '0;
  logic [31:0]  readdata;
  logic [W-1:0] sw_clean;
  logic [W-1:0] rise_pulse;
  logic [W-1:0] fall_pulse;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  switch_debouncer #(.WIDTH(W), .CNT_W(16), .DEBOUNCE_CYCLES(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sw_raw     (sw_raw),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .sw_clean   (sw_clean),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a channel flips once its synchronized level has disagreed with
  // the clean level for thr_eff consecutive edges since it last settled.
  int           m_n = 0;
  int           m_settle [W];
  int unsigned  m_thr = 16;
  logic [W-1:0] m_s1 = '0, m_s2 = '0, m_clean = '0, m_rise = '0, m_fall = '0, m_bnc = '0;
  logic [31:0]  m_rd = '0;

  initial for (int i = 0; i < W; i++) m_settle[i] = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_s1 = '0; m_s2 = '0; m_clean = '0; m_rise = '0; m_fall = '0; m_bnc = '0;
      m_rd = '0; m_thr = 16;
      for (int i = 0; i < W; i++) m_settle[i] = m_n;
    end else begin
      int unsigned  thr_eff;
      logic [W-1:0] set_b;
      logic         clr;
      m_n++;
      thr_eff = (m_thr == 0) ? 1 : m_thr;
      case (address)
        2'd0:    m_rd = 32'(m_clean);
        2'd1:    m_rd = m_thr;
        2'd2:    m_rd = 32'(m_bnc);
        default: m_rd = 0;
      endcase
      clr = chipselect && !write_n && address == 2'd2;
      set_b = '0; m_rise = '0; m_fall = '0;
      for (int i = 0; i < W; i++) begin
        if (m_s2[i] == m_clean[i]) begin
          if (m_settle[i] < m_n - 1) set_b[i] = 1'b1;
          m_settle[i] = m_n;
        end else if (m_n - m_settle[i] >= int'(thr_eff)) begin
          m_clean[i] = m_s2[i];
          if (m_s2[i]) m_rise[i] = 1'b1; else m_fall[i] = 1'b1;
          m_settle[i] = m_n;
        end
      end
      m_bnc = (clr ? '0 : m_bnc) | set_b;
      if (chipselect && !write_n && address == 2'd1) m_thr = writedata[15:0];
      m_s2 = m_s1;
      m_s1 = sw_raw;
    end
  end

  always @(negedge clk) begin
    check("model_sw_clean", 32'(sw_clean), 32'(m_clean));
    check("model_rise_pulse", 32'(rise_pulse), 32'(m_rise));
    check("model_fall_pulse", 32'(fall_pulse), 32'(m_fall));
    check("model_readdata", readdata, m_rd);
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    $display("write addr=%0d data=%0h", a, d);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    @(negedge clk);
    d = readdata; chipselect = 1'b0;
    $display("read  addr=%0d data=%0h", a, d);
  endtask

  task automatic wait_clean(input int ch, input logic lvl, output int k);
    k = -1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (sw_clean[ch] === lvl) begin
        k = i;
        break;
      end
    end
    $display("channel %0d reached %0b after %0d edges", ch, lvl, k);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0]  d;
    logic [W-1:0] fall_seen;
    int           k;

    repeat (3) @(negedge clk);
    check("reset_sw_clean", 32'(sw_clean), 32'h0);
    check("reset_readdata", readdata, 32'h0);
    check("reset_pulses", 32'({rise_pulse, fall_pulse}), 32'h0);
    reset_n = 1'b1;
    bus_read(2'd1, d);
    check("reset_threshold", d, 32'd16);

    // Default threshold: stable rise and fall appear at edge 18.
    sw_raw[0] = 1'b1;
    wait_clean(0, 1'b1, k);
    check("rise_latency_ch0", k, 18);
    check("rise_pulse_ch0", 32'(rise_pulse), 32'h1);
    check("other_channels_idle", 32'(sw_clean), 32'h1);
    @(negedge clk);
    check("rise_pulse_one_cycle", 32'(rise_pulse), 32'h0);
    sw_raw[0] = 1'b0;
    wait_clean(0, 1'b0, k);
    check("fall_latency_ch0", k, 18);
    check("fall_pulse_ch0", 32'(fall_pulse), 32'h1);

    // Short excursion is filtered and recorded as a bounce.
    sw_raw[1] = 1'b1;
    repeat (10) @(negedge clk);
    sw_raw[1] = 1'b0;
    repeat (20) @(negedge clk);
    check("glitch_filtered_ch1", 32'(sw_clean[1]), 32'h0);
    bus_read(2'd2, d);
    check("bnc_ch1_set", d, 32'h2);
    bus_write(2'd2, 32'h0);
    bus_read(2'd2, d);
    check("bnc_cleared", d, 32'h0);

    // Threshold zero acts as one.
    bus_write(2'd1, 32'h0);
    bus_read(2'd1, d);
    check("thr_zero_readback", d, 32'h0);
    sw_raw[2] = 1'b1;
    wait_clean(2, 1'b1, k);
    check("thr_zero_latency", k, 3);
    check("thr_zero_rise_pulse", 32'(rise_pulse), 32'h4);

    // Lowering the threshold mid-count completes on the following edge.
    bus_write(2'd1, 32'd100);
    sw_raw[3] = 1'b1;
    repeat (60) @(negedge clk);
    bus_write(2'd1, 32'd20);
    check("thr_change_not_yet", 32'(sw_clean[3]), 32'h0);
    @(negedge clk);
    check("thr_change_done", 32'(sw_clean[3]), 32'h1);
    check("thr_change_rise", 32'(rise_pulse), 32'h8);

    // Reset with all switches high restores threshold 16 and rises together.
    bus_write(2'd1, 32'd5);
    sw_raw = 4'hF;
    #2 reset_n = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b1;
    fall_seen = '0;
    k = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      fall_seen |= fall_pulse;
      if (sw_clean != '0) begin
        k = i;
        break;
      end
    end
    check("reset_rise_latency", k, 18);
    check("reset_rise_all", 32'(sw_clean), 32'hF);
    check("reset_rise_pulses", 32'(rise_pulse), 32'hF);
    check("reset_no_fall", 32'(fall_seen), 32'h0);
    bus_read(2'd1, d);
    check("reset_thr_reload", d, 32'd16);

    // Clearing write coincides with a bounce abort on channel 0: set wins.
    sw_raw[0] = 1'b0;
    repeat (3) @(negedge clk);
    sw_raw[0] = 1'b1;
    repeat (2) @(negedge clk);
    bus_write(2'd2, 32'h0);
    bus_read(2'd2, d);
    check("bnc_set_beats_clear", d, 32'h1);

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < W; b++)
        if ($urandom_range(0, 9) == 0) sw_raw[b] = ~sw_raw[b];
      address    = 2'($urandom_range(0, 3));
      chipselect = 1'($urandom_range(0, 1));
      write_n    = ($urandom_range(0, 15) != 0);
      writedata  = ($urandom() & 32'hFFFF_0000) | 32'($urandom_range(0, 6));
      if (chipselect && !write_n)
        $display("write addr=%0d data=%0h (random)", address, writedata);
      if ($urandom_range(0, 999) == 0) begin
        #2 reset_n = 1'b0;
        #1 reset_n = 1'b1;
        $display("reset pulse (random)");
      end
      @(negedge clk);
    end
    chipselect = 1'b0;
    write_n = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
